// File: rtl/hl_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed hidden layer.
// Widths are passed in as arguments so one package serves every parameterisation.
package hl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ACT,
    HOLD
  } state_t;

  // Width of the accumulator: the worst-case sum can never overflow it.
  function automatic int acc_width(input int w, input int n_in);
    return 2 * w + 2 + $clog2(n_in + 1);
  endfunction

  // ReLU, drop the fractional bits (truncating), then clamp to w unsigned bits.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] v,
                                           input int frac, input int w);
    logic signed [63:0] q;
    logic signed [63:0] lim;
    q   = v >>> frac;
    lim = (64'sd1 <<< w) - 64'sd1;
    if (v < 0) return '0;
    if (q > lim) return lim;
    return q;
  endfunction

endpackage

// File: rtl/hl_mac_lane.sv
// One neuron: signed multiply-accumulate of unsigned inputs against signed weights,
// bias add, and the activated, saturated output.
module hl_mac_lane
  import hl_pkg::*;
#(
  parameter int W     = 10,
  parameter int FRAC  = 4,
  parameter int ACC_W = 26
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         clr,
  input  logic         acc_en,
  input  logic         bias_en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] wt,
  input  logic [W-1:0] bias,
  output logic [W-1:0] act
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_sh;
  logic signed [ACC_W-1:0] acc_biased;
  logic signed [2*W:0]     prod;

  // The zero bit in front of x keeps the input unsigned inside a signed multiply.
  assign prod       = (2*W+1)'($signed({1'b0, x})) * (2*W+1)'($signed(wt));
  assign bias_sh    = ACC_W'($signed(bias)) <<< FRAC;
  assign acc_biased = acc + bias_sh;
  assign act        = W'(relu_sat(64'(acc_biased), FRAC, W));

  // NOTE: state updates use non-blocking assignments so every lane samples the same pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        acc <= '0;
    else if (clr)     acc <= '0;
    else if (acc_en)  acc <= acc + ACC_W'(prod);
    else if (bias_en) acc <= acc_biased;
  end

endmodule

// File: rtl/hidden_layer_seq.sv
// Fully-connected hidden layer: one input element per cycle into N_NEUR parallel MAC
// lanes, then bias, ReLU, saturation and argmax over the neuron outputs.
module hidden_layer_seq
  import hl_pkg::*;
#(
  parameter int N_IN   = 10,
  parameter int N_NEUR = 10,
  parameter int W      = 10,
  parameter int FRAC   = 4,
  parameter int IDX_W  = (N_NEUR > 1) ? $clog2(N_NEUR) : 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_neur,
  input  logic [$clog2(N_IN+1)-1:0] wr_idx,
  input  logic [W-1:0]             wr_data,
  output logic                     wr_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_NEUR*W-1:0]      out_data,
  output logic [IDX_W-1:0]         out_class
);

  localparam int IW    = $clog2(N_IN + 1);
  localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = acc_width(W, N_IN);

  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic acc_clr, acc_en, bias_en;
  logic wr_ok, neur_ok, idx_ok, wr_state_ok;

  logic [W-1:0] wmem [N_NEUR][N_IN+1];
  logic [W-1:0] xin  [N_IN];
  logic [W-1:0] act  [N_NEUR];
  logic [N_NEUR*W-1:0] act_flat;
  logic [IDX_W-1:0]    best;
  logic [W-1:0]        best_v;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    bias_en   = 1'b0;
    case (state)
      IDLE:  if (in_valid) begin
               state_nxt = ACCUM;
               acc_clr   = 1'b1;
             end
      ACCUM: begin
               acc_en = 1'b1;
               if (k == KW'(N_IN - 1)) state_nxt = ACT;
             end
      ACT:   begin
               bias_en   = 1'b1;
               state_nxt = HOLD;
             end
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      k     <= '0;
      for (int i = 0; i < N_IN; i++) xin[i] <= '0;
    end else begin
      state <= state_nxt;
      if (acc_clr) begin
        k <= '0;
        for (int i = 0; i < N_IN; i++) xin[i] <= in_data[i*W +: W];
      end else if (acc_en) begin
        k <= k + 1'b1;
      end
    end
  end

  // Weight store: writes only while no run is reading it.
  assign wr_state_ok = (state == IDLE) || (state == HOLD);
  assign neur_ok     = {1'b0, wr_neur} < (IDX_W+1)'(N_NEUR);
  assign idx_ok      = {1'b0, wr_idx} < (IW+1)'(N_IN + 1);
  assign wr_ok       = wr_en && wr_state_ok && neur_ok && idx_ok;

  // NOTE: the weight store has no reset; its contents must survive Reset.
  always_ff @(posedge Clock) begin
    if (wr_ok) wmem[wr_neur][wr_idx] <= wr_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) wr_err <= 1'b0;
    else       wr_err <= wr_en && !wr_ok;
  end

  for (genvar j = 0; j < N_NEUR; j++) begin : g_lane
    hl_mac_lane #(
      .W    (W),
      .FRAC (FRAC),
      .ACC_W(ACC_W)
    ) u_lane (
      .Clock  (Clock),
      .Reset  (Reset),
      .clr    (acc_clr),
      .acc_en (acc_en),
      .bias_en(bias_en),
      .x      (xin[k]),
      .wt     (wmem[j][k]),
      .bias   (wmem[j][N_IN]),
      .act    (act[j])
    );
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best     = '0;
    best_v   = act[0];
    act_flat = '0;
    for (int j = 0; j < N_NEUR; j++) begin
      act_flat[j*W +: W] = act[j];
      if (act[j] > best_v) begin
        best_v = act[j];
        best   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_data  <= '0;
      out_class <= '0;
    end else if (state == ACT) begin
      out_data  <= act_flat;
      out_class <= best;
    end
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Bench for hidden_layer_seq: directed scenarios plus randomized vectors checked
// against a plain-arithmetic model of the layer.
module tb_hidden_layer_seq;

  localparam int N_IN   = 10;
  localparam int N_NEUR = 10;
  localparam int W      = 10;
  localparam int FRAC   = 4;
  localparam int IDX_W  = 4;
  localparam int IW     = 4;
  localparam int MAXV   = (1 << W) - 1;

  logic                 Clock = 1'b0;
  logic                 Reset;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_neur;
  logic [IW-1:0]        wr_idx;
  logic [W-1:0]         wr_data;
  logic                 wr_err;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_NEUR*W-1:0]  out_data;
  logic [IDX_W-1:0]     out_class;

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int mw [N_NEUR][N_IN+1];
  logic [N_NEUR*W-1:0] exp_data;
  int                  exp_class;
  logic [N_IN*W-1:0]   vec5, vec_a, vec_b, vec_max;

  hidden_layer_seq #(
    .N_IN  (N_IN),
    .N_NEUR(N_NEUR),
    .W     (W),
    .FRAC  (FRAC),
    .IDX_W (IDX_W)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .wr_en    (wr_en),
    .wr_neur  (wr_neur),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_class(out_class)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    lat++;
  endtask

  task automatic wr(input int n, input int idx, input int val, input logic exp_err);
    wr_en   = 1'b1;
    wr_neur = IDX_W'(n);
    wr_idx  = IW'(idx);
    wr_data = W'(val);
    tick();
    wr_en = 1'b0;
    check("wr_err", wr_err, exp_err);
    if (!exp_err) mw[n][idx] = val;
  endtask

  task automatic load(input int wv, input int bv);
    for (int n = 0; n < N_NEUR; n++) begin
      for (int i = 0; i < N_IN; i++) wr(n, i, wv, 1'b0);
      wr(n, N_IN, bv, 1'b0);
    end
  endtask

  // Reference: dot product plus scaled bias, ReLU, truncating shift, clamp, first max.
  task automatic model(input logic [N_IN*W-1:0] d);
    longint s, a, best;
    best      = -1;
    exp_class = 0;
    for (int j = 0; j < N_NEUR; j++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'(d[i*W +: W]) * longint'(mw[j][i]);
      s += longint'(mw[j][N_IN]) * longint'(1 << FRAC);
      a = (s < 0) ? 0 : s / (1 << FRAC);
      if (a > MAXV) a = MAXV;
      exp_data[j*W +: W] = W'(a);
      if (a > best) begin
        best      = a;
        exp_class = j;
      end
    end
  endtask

  task automatic send(input logic [N_IN*W-1:0] d);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", in_ready, 1);
    model(d);
    in_valid = 1'b1;
    in_data  = d;
    lat      = 0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < N_IN; i++) in_data[i*W +: W] = W'($urandom);
  endtask

  task automatic collect(input int hold, input logic [N_IN*W-1:0] next_d, input logic next_v);
    while (!out_valid && lat < 200) tick();
    check("latency", lat, N_IN + 2);
    check("out_data", out_data, exp_data);
    check("out_class", out_class, exp_class);
    check("in_ready_hold", in_ready, 0);
    if (next_v) begin
      in_valid = 1'b1;
      in_data  = next_d;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_data);
      check("hold_class", out_class, exp_class);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    Reset     = 1'b1;
    wr_en     = 1'b0;
    wr_neur   = '0;
    wr_idx    = '0;
    wr_data   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      vec5[i*W +: W]    = W'(5);
      vec_max[i*W +: W] = W'(MAXV);
    end
    @(negedge Clock);
    @(negedge Clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_class", out_class, 0);
    check("rst_wr_err", wr_err, 0);
    Reset = 1'b0;
    tick();

    // Uniform unit weights: every neuron 50, tie resolves to class 0.
    load(16, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_no_effect", out_valid, 0);
    send(vec5);
    collect(0, '0, 1'b0);

    // One heavier neuron wins; negative weights clip to zero.
    for (int i = 0; i < N_IN; i++) wr(3, i, 32, 1'b0);
    send(vec5);
    collect(0, '0, 1'b0);
    load(-16, 0);
    send(vec5);
    collect(0, '0, 1'b0);

    // Saturation at full scale, then bias-only output.
    load(511, 0);
    send(vec_max);
    collect(0, '0, 1'b0);
    load(0, 7);
    send(vec5);
    collect(0, '0, 1'b0);

    // Back-pressure in HOLD with a second vector waiting, then back-to-back acceptance.
    load(16, 0);
    for (int i = 0; i < N_IN; i++) begin
      vec_a[i*W +: W] = W'($urandom_range(1023, 0));
      vec_b[i*W +: W] = W'($urandom_range(1023, 0));
    end
    wr(5, 2, 40, 1'b0);
    send(vec_a);
    collect(5, vec_b, 1'b1);
    send(vec_b);
    collect(0, '0, 1'b0);
    wr(5, 2, 16, 1'b0);

    // Writes during a run are rejected; out-of-range neuron rejected; IDLE write lands.
    send(vec5);
    wr(0, 0, 100, 1'b1);
    tick();
    check("wr_err_pulse", wr_err, 0);
    collect(0, '0, 1'b0);
    wr(12, 0, 5, 1'b1);
    wr(0, 0, 100, 1'b0);
    send(vec5);
    collect(0, '0, 1'b0);

    // Reset in the middle of accumulation; weights survive.
    wr(0, 0, 16, 1'b0);
    send(vec5);
    while (lat < 4) tick();
    Reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      check("midrst_no_valid", out_valid, 0);
    end
    send(vec5);
    collect(0, '0, 1'b0);

    // Randomized weights, biases, inputs and hold times.
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < N_NEUR; n++) begin
        for (int i = 0; i < N_IN; i++) begin
          if (it % 2 == 0) wr(n, i, int'($urandom_range(16, 0)) - 8, 1'b0);
          else             wr(n, i, int'($urandom_range(1023, 0)) - 512, 1'b0);
        end
        wr(n, N_IN, int'($urandom_range(1023, 0)) - 512, 1'b0);
      end
      for (int i = 0; i < N_IN; i++) vec_a[i*W +: W] = W'($urandom_range(1023, 0));
      send(vec_a);
      collect(int'($urandom_range(3, 0)), '0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hidden_layer_seq.md
Name: hidden_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected hidden layer for the drowsiness classifier.
- Holds an on-chip weight/bias store loaded through a write port.
- Accepts one input feature vector per valid/ready handshake and runs one MAC lane per neuron, one input per cycle.
- Emits the ReLU-activated, saturated neuron vector plus the argmax class index to the output layer / decision logic.

Parameters:
N_IN, 10, inputs per vector
N_NEUR, 10, neurons in the layer
W, 10, data/weight width in bits
FRAC, 4, fractional bits of the weight/bias fixed-point format
IDX_W, $clog2(N_NEUR) (min 1), argmax index width

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
wr_en  in  1  weight/bias write strobe
wr_neur  in  $clog2(N_NEUR)  target neuron
wr_idx  in  $clog2(N_IN+1)  input index; value N_IN selects the bias
wr_data  in  W  signed weight or bias
wr_err  out  1  one-cycle pulse: write rejected
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  N_IN*W  unsigned inputs, element k at bits [k*W +: W]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  N_NEUR*W  unsigned activations, neuron j at [j*W +: W]
out_class  out  IDX_W  index of largest activation

Behaviour:
- Reset (async, active-high): state IDLE; in_ready=1, out_valid=0, out_data=0, out_class=0, wr_err=0, accumulators and counter cleared.
- Weight/bias store is not reset. Contents persist across Reset.
- Writes: accepted only in IDLE or HOLD and take effect next cycle. wr_en in ACCUM or ACT is ignored and wr_err pulses for 1 cycle. wr_neur >= N_NEUR is ignored with a wr_err pulse.
- FSM states: IDLE, ACCUM, ACT, HOLD.
  - IDLE: in_ready=1. On in_valid&in_ready: latch in_data, clear accumulators, k=0, go to ACCUM.
  - ACCUM: each cycle acc[j] += in[k]*w[j][k] for all j in parallel; k++. After the cycle with k=N_IN-1, go to ACT. ACCUM lasts exactly N_IN cycles.
  - ACT: acc[j] += bias[j] <<< FRAC. Then ReLU (negative -> 0), >> FRAC (truncate), saturate to 2^W-1. Register out_data; compute out_class (lowest index wins ties). Go to HOLD.
  - HOLD: out_valid=1, outputs stable. On out_ready: out_valid drops next cycle, return to IDLE. in_ready=0 in HOLD (no overlap).
- Latency: handshake in cycle 0 -> out_valid high in cycle N_IN+2.
- Arithmetic: inputs unsigned W bits, weights/bias signed W bits. Products signed 2W+1. Accumulator ACC_W = 2W+2+$clog2(N_IN+1), signed, no overflow possible.
- in_data changes after acceptance are ignored.
- out_ready while not out_valid has no effect.
- Reset mid-ACCUM/ACT/HOLD: immediate return to IDLE, partial result discarded, no out_valid.

Decomposition:
- Package hl_pkg: state enum (IDLE/ACCUM/ACT/HOLD), ACC_W width function, saturate/ReLU function.
- Sub-module hl_mac_lane: one neuron's accumulator with clear/accumulate/bias-add controls and an activation output. Instantiate N_NEUR times in a generate loop.
- Weight store, counter, FSM and argmax stay in the top.

Test Plan:
1. All weights 16 (1.0), biases 0, inputs all 5 -> each out_data element 50; out_class=0 (tie); out_valid exactly 12 cycles after the handshake.
2. Neuron 3 weights 32, others 16, biases 0, inputs 5 -> neuron 3 = 100, others 50; out_class=3. All weights -16 -> all outputs 0 (ReLU).
3. Weights 511, inputs 1023 -> all outputs saturate to 1023. Bias only (weights 0, bias 7) -> outputs 7.
4. Hold out_ready=0 for 5 cycles in HOLD -> out_data/out_class stable, in_ready=0, second in_valid not accepted. Then out_ready=1 -> back-to-back second vector accepted next IDLE cycle with correct result.
5. wr_en during ACCUM (neuron 0, idx 0, value 100) -> wr_err pulses 1 cycle, the following run uses the old weight. Same write in IDLE -> no wr_err, new weight used.
6. Assert Reset in ACCUM cycle 4 -> in_ready=1, out_valid=0 immediately. Weights retained: the next run gives the same result as scenario 1.
